recovery_request_arbiter: RTL and testbench

RECOVERY_REQUEST_ARBITER -- requirements
Module: recovery_request_arbiter

---
 rtl/recovery_request_arbiter_pkg.sv | 39 +++
 rtl/recovery_request_arbiter_age_compare.sv | 24 ++
 rtl/recovery_request_arbiter.sv | 167 ++++++++++++++++
 tb/tb_recovery_request_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recovery_request_arbiter_pkg.sv
// Pipeline types shared by the recovery request arbiter and its age comparator.
// Request pointers are carried at a fixed maximum width and masked to AL_IDX_W where compared.
package PipelineTypes;

    localparam int ADDR_WIDTH   = 32;
    localparam int AL_IDX_MAX_W = 16;

    typedef logic [ADDR_WIDTH-1:0]   AddrPath;
    typedef logic [AL_IDX_MAX_W-1:0] ActiveListIndexPath;

    typedef enum logic [1:0] {
        REFETCH_TYPE_THIS_PC,
        REFETCH_TYPE_NEXT_PC,
        REFETCH_TYPE_BRANCH_TARGET,
        REFETCH_TYPE_STORE_NEXT_PC
    } RefetchType;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GRANT,
        WAIT
    } RecoveryArbStatePath;

    typedef struct packed {
        ActiveListIndexPath ptr;
        AddrPath            pc;
        RefetchType         refetchType;
        logic               fromRw;
    } RecoveryRequestPath;

    localparam RecoveryRequestPath RECOVERY_REQ_RESET = '{
        ptr:         '0,
        pc:          '0,
        refetchType: REFETCH_TYPE_THIS_PC,
        fromRw:      1'b0
    };

endpackage

// File: rtl/recovery_request_arbiter_age_compare.sv
// Combinational ActiveList age comparator: aOlder when ptrA is strictly older than ptrB.
// Age is the distance from the head, modulo 2^W.
module recovery_age_compare
    import PipelineTypes::*;
#(
    parameter int W = 6
) (
    input  ActiveListIndexPath ptrA,
    input  ActiveListIndexPath ptrB,
    input  ActiveListIndexPath head,
    output logic               aOlder
);

    localparam ActiveListIndexPath MASK =
        ActiveListIndexPath'((32'd1 << W) - 32'd1);

    ActiveListIndexPath ageA;
    ActiveListIndexPath ageB;

    assign ageA   = (ptrA - head) & MASK;
    assign ageB   = (ptrB - head) & MASK;
    assign aOlder = ageA < ageB;

endmodule

// File: rtl/recovery_request_arbiter.sv
// Arbitrates commit-stage and RW-stage recovery requests into one grant per recovery.
// Define RSD_RECOVERY_ARB_DROP_COUNT_EN to build the saturating dropped-request counter.
module recovery_request_arbiter
    import PipelineTypes::*;
#(
    parameter int AL_IDX_W   = 6,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmReqValid,
    input  logic [AL_IDX_W-1:0]   cmReqPtr,
    input  AddrPath               cmReqPC,
    input  RefetchType            cmReqRefetchType,
    input  logic                  rwReqValid,
    input  logic [AL_IDX_W-1:0]   rwReqPtr,
    input  AddrPath               rwReqPC,
    input  RefetchType            rwReqRefetchType,
    input  logic [AL_IDX_W-1:0]   alHeadPtr,
    input  logic                  unableToStartRecovery,
    input  logic                  toCommitPhase,
    output logic                  grantValid,
    output logic                  grantFromRw,
    output logic [AL_IDX_W-1:0]   grantPtr,
    output AddrPath               grantPC,
    output RefetchType            grantRefetchType,
    output logic                  pending,
    output logic [DROP_CNT_W-1:0] dropCount
);

    RecoveryArbStatePath state;
    RecoveryArbStatePath nextState;
    RecoveryRequestPath  cmReq;
    RecoveryRequestPath  rwReq;
    RecoveryRequestPath  newReq;
    RecoveryRequestPath  bufReq;
    RecoveryRequestPath  bufNext;
    ActiveListIndexPath  headExt;
    logic                newValid;
    logic                rwOlder;
    logic                newOlder;

    assign headExt = ActiveListIndexPath'(alHeadPtr);

    assign cmReq = '{
        ptr:         ActiveListIndexPath'(cmReqPtr),
        pc:          cmReqPC,
        refetchType: cmReqRefetchType,
        fromRw:      1'b0
    };

    assign rwReq = '{
        ptr:         ActiveListIndexPath'(rwReqPtr),
        pc:          rwReqPC,
        refetchType: rwReqRefetchType,
        fromRw:      1'b1
    };

    recovery_age_compare #(.W(AL_IDX_W)) rwVsCm (
        .ptrA   (rwReq.ptr),
        .ptrB   (cmReq.ptr),
        .head   (headExt),
        .aOlder (rwOlder)
    );

    // Commit wins ties: RW is chosen only when strictly older.
    assign newValid = cmReqValid | rwReqValid;
    assign newReq   = (rwReqValid && (!cmReqValid || rwOlder)) ? rwReq : cmReq;

    recovery_age_compare #(.W(AL_IDX_W)) newVsBuf (
        .ptrA   (newReq.ptr),
        .ptrB   (bufReq.ptr),
        .head   (headExt),
        .aOlder (newOlder)
    );

    always_comb begin
        nextState = state;
        bufNext   = bufReq;
        unique case (state)
            IDLE: begin
                if (newValid) begin
                    bufNext   = newReq;
                    nextState = unableToStartRecovery ? HOLD : GRANT;
                end
            end
            HOLD: begin
                if (newValid && newOlder) begin
                    bufNext = newReq;
                end
                if (!unableToStartRecovery) begin
                    nextState = GRANT;
                end
            end
            GRANT: begin
                nextState = WAIT;
            end
            WAIT: begin
                if (toCommitPhase) begin
                    nextState = IDLE;
                end
            end
        endcase
    end

    assign grantValid = (state == GRANT);
    assign pending    = (state == HOLD) || (state == GRANT);

    // Grant fields load only on entry to GRANT, so they hold outside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            bufReq           <= RECOVERY_REQ_RESET;
            grantFromRw      <= 1'b0;
            grantPtr         <= '0;
            grantPC          <= '0;
            grantRefetchType <= REFETCH_TYPE_THIS_PC;
        end else begin
            state  <= nextState;
            bufReq <= bufNext;
            if (nextState == GRANT) begin
                grantFromRw      <= bufNext.fromRw;
                grantPtr         <= bufNext.ptr[AL_IDX_W-1:0];
                grantPC          <= bufNext.pc;
                grantRefetchType <= bufNext.refetchType;
            end
        end
    end

`ifdef RSD_RECOVERY_ARB_DROP_COUNT_EN
    logic [1:0]            arrivals;
    logic [1:0]            dropInc;
    logic                  bothValid;
    logic [DROP_CNT_W:0]   dropSum;
    logic [DROP_CNT_W-1:0] dropCountQ;

    assign bothValid = cmReqValid & rwReqValid;
    assign arrivals  = 2'(cmReqValid) + 2'(rwReqValid);

    // Only the request actually stored in IDLE/HOLD escapes being counted.
    always_comb begin
        dropInc = arrivals;
        if (state == IDLE) begin
            dropInc = {1'b0, bothValid};
        end else if (state == HOLD && newOlder) begin
            dropInc = {1'b0, bothValid};
        end
    end

    assign dropSum = {1'b0, dropCountQ} + (DROP_CNT_W + 1)'(dropInc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropCountQ <= '0;
        end else if (dropSum[DROP_CNT_W]) begin
            dropCountQ <= '1;
        end else begin
            dropCountQ <= dropSum[DROP_CNT_W-1:0];
        end
    end

    assign dropCount = dropCountQ;
`else
    assign dropCount = '0;
`endif

endmodule

// File: tb/tb_recovery_request_arbiter.sv
// Directed and random bench for recovery_request_arbiter against a set-based reference model.
// Expected dropCount follows RSD_RECOVERY_ARB_DROP_COUNT_EN.
module tb_recovery_request_arbiter;
    import PipelineTypes::*;

    localparam int W   = 6;
    localparam int DW  = 16;
    localparam int MOD = 1 << W;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmReqValid;
    logic [W-1:0]  cmReqPtr;
    AddrPath       cmReqPC;
    RefetchType    cmReqRefetchType;
    logic          rwReqValid;
    logic [W-1:0]  rwReqPtr;
    AddrPath       rwReqPC;
    RefetchType    rwReqRefetchType;
    logic [W-1:0]  alHeadPtr;
    logic          unableToStartRecovery;
    logic          toCommitPhase;
    logic          grantValid;
    logic          grantFromRw;
    logic [W-1:0]  grantPtr;
    AddrPath       grantPC;
    RefetchType    grantRefetchType;
    logic          pending;
    logic [DW-1:0] dropCount;

    recovery_request_arbiter #(.AL_IDX_W(W), .DROP_CNT_W(DW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmReqValid            (cmReqValid),
        .cmReqPtr              (cmReqPtr),
        .cmReqPC               (cmReqPC),
        .cmReqRefetchType      (cmReqRefetchType),
        .rwReqValid            (rwReqValid),
        .rwReqPtr              (rwReqPtr),
        .rwReqPC               (rwReqPC),
        .rwReqRefetchType      (rwReqRefetchType),
        .alHeadPtr             (alHeadPtr),
        .unableToStartRecovery (unableToStartRecovery),
        .toCommitPhase         (toCommitPhase),
        .grantValid            (grantValid),
        .grantFromRw           (grantFromRw),
        .grantPtr              (grantPtr),
        .grantPC               (grantPC),
        .grantRefetchType      (grantRefetchType),
        .pending               (pending),
        .dropCount             (dropCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ptr;
        logic [31:0] pc;
        int         rt;
        bit         fromRw;
    } req_t;

    int   total = 0;
    int   bad   = 0;
    req_t mBuf;
    req_t mGrant;
    bit   mHave;
    bit   mGranting;
    bit   mWaiting;
    int   mDrops;
    int   dropBase;

    function automatic int age(int p, int h);
        return (p - h + MOD) % MOD;
    endfunction

    function automatic int expDrop();
`ifdef RSD_RECOVERY_ARB_DROP_COUNT_EN
        return (mDrops > 65535) ? 65535 : mDrops;
`else
        return 0;
`endif
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(string tag);
        check({tag, ".grantValid"}, 64'(grantValid), 64'(mGranting));
        check({tag, ".pending"}, 64'(pending), 64'(mHave | mGranting));
        check({tag, ".fromRw"}, 64'(grantFromRw), 64'(mGrant.fromRw));
        check({tag, ".ptr"}, 64'(grantPtr), 64'(mGrant.ptr));
        check({tag, ".pc"}, 64'(grantPC), 64'(mGrant.pc));
        check({tag, ".rt"}, 64'(grantRefetchType), 64'(mGrant.rt));
        check({tag, ".drop"}, 64'(dropCount), 64'(expDrop()));
    endtask

    task automatic modelReset();
        mHave     = 0;
        mGranting = 0;
        mWaiting  = 0;
        mDrops    = 0;
        mBuf      = '{0, 32'h0, 0, 1'b0};
        mGrant    = '{0, 32'h0, int'(REFETCH_TYPE_THIS_PC), 1'b0};
    endtask

    // Candidates in priority order: buffer, commit, RW; strictly older wins.
    task automatic modelStep();
        req_t cand[2];
        bit   cv[2];
        int   nNew;
        bit   have;
        bit   newWon;
        req_t best;
        cand[0] = '{int'(cmReqPtr), cmReqPC, int'(cmReqRefetchType), 1'b0};
        cand[1] = '{int'(rwReqPtr), rwReqPC, int'(rwReqRefetchType), 1'b1};
        cv[0]   = cmReqValid;
        cv[1]   = rwReqValid;
        nNew    = int'(cmReqValid) + int'(rwReqValid);
        if (mGranting) begin
            mDrops    += nNew;
            mGranting = 0;
            mWaiting  = 1;
        end else if (mWaiting) begin
            mDrops += nNew;
            if (toCommitPhase) mWaiting = 0;
        end else begin
            have   = mHave;
            best   = mBuf;
            newWon = 0;
            for (int i = 0; i < 2; i++) begin
                if (cv[i] && (!have ||
                    age(cand[i].ptr, int'(alHeadPtr)) <
                    age(best.ptr, int'(alHeadPtr)))) begin
                    best   = cand[i];
                    have   = 1;
                    newWon = 1;
                end
            end
            mDrops += nNew - int'(newWon);
            mBuf   = best;
            mHave  = have;
            if (have && !unableToStartRecovery) begin
                mGrant    = best;
                mGranting = 1;
                mHave     = 0;
            end
        end
    endtask

    task automatic idleInputs();
        cmReqValid            = 0;
        rwReqValid            = 0;
        toCommitPhase         = 0;
        unableToStartRecovery = 0;
    endtask

    task automatic cycle(string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        rst                   = 0;
        cmReqPtr              = '0;
        cmReqPC               = '0;
        cmReqRefetchType      = REFETCH_TYPE_THIS_PC;
        rwReqPtr              = '0;
        rwReqPC               = '0;
        rwReqRefetchType      = REFETCH_TYPE_THIS_PC;
        alHeadPtr             = '0;
        idleInputs();
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset");
        rst = 1;
        cycle("idle");

        // Single commit request, not busy: grant next cycle, then WAIT.
        cmReqValid       = 1;
        cmReqPtr         = 0;
        cmReqPC          = 32'h0000_1000;
        cmReqRefetchType = REFETCH_TYPE_NEXT_PC;
        cycle("r022.grant");
        check("r022.grantValid", 64'(grantValid), 64'd1);
        check("r022.fromRw", 64'(grantFromRw), 64'd0);
        idleInputs();
        cycle("r022.wait0");
        cycle("r022.wait1");
        check("r022.noRegrant", 64'(grantValid), 64'd0);
        toCommitPhase = 1;
        cycle("r022.commit");
        idleInputs();

        // Simultaneous: head 62, RW ptr 1 (age 3), commit ptr 63 (age 1).
        dropBase         = int'(dropCount);
        alHeadPtr        = 62;
        rwReqValid       = 1;
        rwReqPtr         = 1;
        rwReqPC          = 32'h0000_2000;
        cmReqValid       = 1;
        cmReqPtr         = 63;
        cmReqPC          = 32'h0000_3000;
        cmReqRefetchType = REFETCH_TYPE_BRANCH_TARGET;
        cycle("r023.grant");
        check("r023.fromRw", 64'(grantFromRw), 64'd0);
        check("r023.ptr", 64'(grantPtr), 64'd63);
`ifdef RSD_RECOVERY_ARB_DROP_COUNT_EN
        check("r023.drop", 64'(dropCount), 64'(dropBase + 1));
`else
        check("r027.drop", 64'(dropCount), 64'd0);
`endif
        idleInputs();
        cycle("r023.wait");
        toCommitPhase = 1;
        cycle("r023.commit");
        idleInputs();

        // Busy: RW ptr 5 buffered, then older RW ptr 3 replaces it.
        dropBase              = int'(dropCount);
        alHeadPtr             = 0;
        unableToStartRecovery = 1;
        rwReqValid            = 1;
        rwReqPtr              = 5;
        rwReqPC               = 32'h0000_5000;
        cycle("r024.hold");
        check("r024.pending", 64'(pending), 64'd1);
        rwReqPtr = 3;
        rwReqPC  = 32'h0000_3300;
        cycle("r024.replace");
        rwReqValid = 0;
        cycle("r024.busy3");
        unableToStartRecovery = 0;
        cycle("r024.grant");
        check("r024.ptr", 64'(grantPtr), 64'd3);
        check("r024.drop", 64'(dropCount), 64'(dropBase));

        // Request during WAIT is dropped.
        cycle("r025.wait");
        dropBase   = int'(dropCount);
        rwReqValid = 1;
        rwReqPtr   = 9;
        cycle("r025.drop");
        check("r025.noGrant", 64'(grantValid), 64'd0);
        idleInputs();
        toCommitPhase = 1;
        cycle("r025.commit");
        idleInputs();
        cycle("r025.idle");
        check("r025.pending", 64'(pending), 64'd0);

        // Asynchronous reset while holding a request.
        unableToStartRecovery = 1;
        cmReqValid            = 1;
        cmReqPtr              = 7;
        cycle("r026.hold");
        idleInputs();
        rst = 0;
        #1;
        modelReset();
        check("r026.pendingNow", 64'(pending), 64'd0);
        checkAll("r026.inReset");
        @(posedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("r026.after");
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cmReqValid            = ($urandom % 3) == 0;
            rwReqValid            = ($urandom % 3) == 0;
            cmReqPtr              = W'($urandom);
            rwReqPtr              = W'($urandom);
            cmReqPC               = $urandom;
            rwReqPC               = $urandom;
            cmReqRefetchType      = RefetchType'($urandom_range(0, 3));
            rwReqRefetchType      = RefetchType'($urandom_range(0, 3));
            alHeadPtr             = W'($urandom);
            unableToStartRecovery = ($urandom % 3) == 0;
            toCommitPhase         = ($urandom % 4) == 0;
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
